schmitt_threshold_ctrl: RTL and testbench

- Adaptive hysteresis controller for the Schmitt-trigger comparator on the ADC sample path.
- Measures the min and max of the signed input over a programmable window, derives the hysteresis magnitude from the peak-to-peak amplitude, and drives the comparator's threshold input.
- Flags a loss-of-signal condition and repeats the measurement continuously while enabled.

---
 rtl/schmitt_threshold_ctrl_if.sv | 33 +++
 rtl/schmitt_threshold_ctrl.sv | 160 ++++++++++++++++
 tb/tb_schmitt_threshold_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/schmitt_threshold_ctrl_if.sv
//------------------------------------------------------------------------------
// schmitt_threshold_ctrl_if : sample stream, control and threshold result bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface schmitt_threshold_ctrl_if #(
    parameter int WD    = 14,
    parameter int WIN_W = 16
);
    logic                 en;
    logic                 din_valid;
    logic signed [WD-1:0] din;
    logic [WIN_W-1:0]     win_len;
    logic signed [WD-1:0] threshold;
    logic [WD:0]          amp;
    logic                 th_valid;
    logic                 upd;
    logic                 low_sig;
    logic                 busy;

    modport master (
        output en, din_valid, din, win_len,
        input  threshold, amp, th_valid, upd, low_sig, busy
    );

    modport slave (
        input  en, din_valid, din, win_len,
        output threshold, amp, th_valid, upd, low_sig, busy
    );
endinterface

`default_nettype wire

// File: rtl/schmitt_threshold_ctrl.sv
//------------------------------------------------------------------------------
// schmitt_threshold_ctrl : windowed min/max amplitude -> adaptive hysteresis
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module schmitt_threshold_ctrl #(
    parameter int WD     = 14,
    parameter int WIN_W  = 16,
    parameter int SHIFT  = 3,
    parameter int TH_MIN = 16
) (
    input  wire                      clk,
    input  wire                      rstn,
    schmitt_threshold_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_CALC  = 2'd2,
        ST_APPLY = 2'd3
    } state_e;

    localparam logic signed [WD-1:0] SMAX     = {1'b0, {(WD-1){1'b1}}};
    localparam logic signed [WD-1:0] SMIN     = {1'b1, {(WD-1){1'b0}}};
    localparam logic signed [WD-1:0] TH_FLOOR = WD'(TH_MIN);
    localparam logic [WD:0]          TH_MIN_U = (WD+1)'(TH_MIN);
    localparam logic [WD:0]          SMAX_U   = {2'b00, {(WD-1){1'b1}}};

    state_e               state_q, state_d;
    logic [WIN_W-1:0]     len_q, len_d;
    logic [WIN_W-1:0]     cnt_q, cnt_d;
    logic signed [WD-1:0] max_q, max_d;
    logic signed [WD-1:0] min_q, min_d;
    logic [WD:0]          ampr_q, ampr_d;
    logic signed [WD-1:0] threshold_q, threshold_d;
    logic [WD:0]          amp_q, amp_d;
    logic                 th_valid_q, th_valid_d;
    logic                 upd_q, upd_d;
    logic                 low_sig_q, low_sig_d;
    logic                 busy_q, busy_d;
    logic                 start_win;
    logic [WD:0]          cand;

    assign cand = ampr_q >> SHIFT;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        min_d       = min_q;
        ampr_d      = ampr_q;
        threshold_d = threshold_q;
        amp_d       = amp_q;
        th_valid_d  = th_valid_q;
        low_sig_d   = low_sig_q;
        upd_d       = 1'b0;
        start_win   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d   = ST_ACQ;
                    start_win = 1'b1;
                end
            end
            ST_ACQ: begin
                // Dropping en abandons the partial window; it beats a final sample.
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (bus.din_valid) begin
                    max_d = (bus.din > max_q) ? bus.din : max_q;
                    min_d = (bus.din < min_q) ? bus.din : min_q;
                    cnt_d = cnt_q + WIN_W'(1);
                    if (cnt_q == len_q - WIN_W'(1)) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Sign-extended difference; max >= min so the result is non-negative.
                ampr_d  = {max_q[WD-1], max_q} - {min_q[WD-1], min_q};
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                amp_d      = ampr_q;
                upd_d      = 1'b1;
                th_valid_d = 1'b1;
                if (cand < TH_MIN_U) begin
                    threshold_d = TH_FLOOR;
                    low_sig_d   = 1'b1;
                end else if (cand > SMAX_U) begin
                    threshold_d = SMAX;
                    low_sig_d   = 1'b0;
                end else begin
                    threshold_d = $signed(cand[WD-1:0]);
                    low_sig_d   = 1'b0;
                end
                if (bus.en) begin
                    state_d   = ST_ACQ;
                    start_win = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_win) begin
            len_d = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
            cnt_d = '0;
            max_d = SMIN;
            min_d = SMAX;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            len_q       <= WIN_W'(1);
            cnt_q       <= '0;
            max_q       <= SMIN;
            min_q       <= SMAX;
            ampr_q      <= '0;
            threshold_q <= TH_FLOOR;
            amp_q       <= '0;
            th_valid_q  <= 1'b0;
            upd_q       <= 1'b0;
            low_sig_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            ampr_q      <= ampr_d;
            threshold_q <= threshold_d;
            amp_q       <= amp_d;
            th_valid_q  <= th_valid_d;
            upd_q       <= upd_d;
            low_sig_q   <= low_sig_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.threshold = threshold_q;
    assign bus.amp       = amp_q;
    assign bus.th_valid  = th_valid_q;
    assign bus.upd       = upd_q;
    assign bus.low_sig   = low_sig_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_schmitt_threshold_ctrl.sv
//------------------------------------------------------------------------------
// tb_schmitt_threshold_ctrl : scoreboard bench for the adaptive hysteresis block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_schmitt_threshold_ctrl;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    typedef struct {
        logic [14:0]        amp;
        logic signed [13:0] th;
        logic               low;
    } exp_t;

    exp_t sbq[$];
    exp_t last;

    schmitt_threshold_ctrl_if #(.WD(14), .WIN_W(16)) bus ();

    schmitt_threshold_ctrl #(
        .WD(14), .WIN_W(16), .SHIFT(3), .TH_MIN(16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic put(input logic v, input int d);
        bus.din_valid = v;
        bus.din       = 14'(d);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    // Reference: min/max over the window, amplitude, shifted candidate, clamped.
    function automatic exp_t model(input int s[$]);
        exp_t e;
        int   mx, mn, a, c;
        mx = -8192;
        mn = 8191;
        foreach (s[i]) begin
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
        end
        a = mx - mn;
        c = a / 8;
        e.amp = 15'(a);
        e.low = (c < 16);
        e.th  = (c < 16) ? 14'sd16 : (c > 8191) ? 14'sd8191 : 14'(c);
        return e;
    endfunction

    task automatic send_window(input int s[$], input int gap);
        sbq.push_back(model(s));
        foreach (s[i]) begin
            put(1'b1, s[i]);
            if (i != s.size() - 1)
                for (int g = 0; g < gap; g++) put(1'b0, 0);
        end
    endtask

    task automatic wait_upd();
        int   n;
        exp_t e;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (bus.upd === 1'b1 || n >= 10) break;
        end
        checks++;
        if (bus.upd !== 1'b1) begin
            errors++;
            $display("FAIL upd_timeout: upd=%b after %0d cycles, required 1", bus.upd, n);
            return;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL upd_latency: got %0d cycles, required 3", n);
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL upd_unexpected: upd with empty scoreboard");
            return;
        end
        e = sbq.pop_front();
        last = e;
        checks++;
        if (bus.amp !== e.amp) begin
            errors++;
            $display("FAIL amp: got %0d, required %0d", bus.amp, e.amp);
        end
        checks++;
        if (bus.threshold !== e.th) begin
            errors++;
            $display("FAIL threshold: got %0d, required %0d", bus.threshold, e.th);
        end
        checks++;
        if (bus.low_sig !== e.low) begin
            errors++;
            $display("FAIL low_sig: got %b, required %b", bus.low_sig, e.low);
        end
        checks++;
        if (bus.th_valid !== 1'b1) begin
            errors++;
            $display("FAIL th_valid: got %b, required 1", bus.th_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.upd !== 1'b0) begin
            errors++;
            $display("FAIL upd_pulse_width: got %b one cycle later, required 0", bus.upd);
        end
    endtask

    task automatic start_run(input int len);
        bus.en = 1'b0;
        put(1'b0, 0);
        put(1'b0, 0);
        bus.win_len = 16'(len);
        bus.en      = 1'b1;
        put(1'b0, 0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got %b, required 1", bus.busy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.threshold !== 14'sd16 || bus.amp !== 15'd0 || bus.th_valid !== 1'b0 ||
            bus.upd !== 1'b0 || bus.low_sig !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: th=%0d amp=%0d thv=%b upd=%b low=%b busy=%b, required 16 0 0 0 0 0",
                     tag, bus.threshold, bus.amp, bus.th_valid, bus.upd, bus.low_sig, bus.busy);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.en = 1'b0;
        bus.din_valid = 1'b0;
        bus.din = '0;
        bus.win_len = 16'd8;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_released");
    endtask

    task automatic test_basic();
        int s[$];
        start_run(8);
        s = {};
        for (int i = 0; i < 8; i++) s.push_back((i % 2 == 0) ? 1000 : -1000);
        send_window(s, 0);
        wait_upd();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL auto_restart_busy: got %b, required 1", bus.busy);
        end
        s = {};
        for (int i = 0; i < 8; i++) s.push_back((i % 2 == 0) ? 300 : -700);
        send_window(s, 1);
        wait_upd();
    endtask

    task automatic test_low_sig();
        int s[$];
        start_run(4);
        s = '{50, -50, 50, -50};
        send_window(s, 0);
        wait_upd();
        s = '{1000, -1000, 1000, -1000};
        send_window(s, 0);
        wait_upd();
    endtask

    task automatic test_fullscale();
        int s[$];
        start_run(2);
        s = '{-8192, 8191};
        send_window(s, 0);
        wait_upd();
    endtask

    task automatic test_abort();
        int n_upd;
        start_run(16);
        for (int i = 0; i < 10; i++) begin
            put(1'b1, (i % 2 == 0) ? 5000 : -5000);
            put(1'b0, 0);
            put(1'b0, 0);
        end
        bus.en = 1'b0;
        n_upd = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.upd === 1'b1) n_upd++;
        end
        checks++;
        if (n_upd !== 0) begin
            errors++;
            $display("FAIL abort_no_upd: got %0d upd pulses, required 0", n_upd);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, required 0", bus.busy);
        end
        checks++;
        if (bus.threshold !== last.th || bus.amp !== last.amp || bus.low_sig !== last.low) begin
            errors++;
            $display("FAIL abort_retain: th=%0d amp=%0d low=%b, required %0d %0d %b",
                     bus.threshold, bus.amp, bus.low_sig, last.th, last.amp, last.low);
        end
    endtask

    task automatic test_win_zero();
        int s[$];
        // Samples offered while idle must not leak into the next window.
        put(1'b1, 4000);
        put(1'b1, -4000);
        start_run(0);
        s = '{500};
        send_window(s, 0);
        wait_upd();
    endtask

    task automatic test_async_reset();
        int s[$];
        start_run(8);
        for (int i = 0; i < 5; i++) put(1'b1, (i % 2 == 0) ? 4000 : -4000);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        start_run(8);
        s = {};
        for (int i = 0; i < 8; i++) s.push_back(i * 100);
        send_window(s, 0);
        wait_upd();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_low_sig();
        test_fullscale();
        test_abort();
        test_win_zero();
        test_async_reset();
        checks++;
        if (sbq.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
